act_unit_pipe: RTL and testbench
================================

Name: act_unit_pipe

Overview:
- Pipelined, parametrised activation unit for the FFN datapath. Sits between the systolic-array accumulator output and the layer writeback / backprop path.
- Computes sigmoid, sigmoid derivative, ReLU or passthrough per sample, selected by a per-sample mode.
- Uses valid/ready streaming with backpressure and keeps a saturation event counter.

Parameters:
- DATA_WIDTH, 16, signed fixed-point input/output width
- FRAC_BITS, 8, fractional bits of input and output (Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS)
- MAX_INT, 3, LUT covers |z| < 2^MAX_INT; beyond that the output saturates
- CNT_WIDTH, 16, width of the saturation counter

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- in_valid_i  in  1  input sample valid
- in_ready_o  out  1  unit accepts a sample this cycle
- z_i  in  DATA_WIDTH  signed pre-activation
- mode_i  in  2  00 sigmoid, 01 sigmoid derivative, 10 ReLU, 11 passthrough
- out_valid_o  out  1  result valid
- out_ready_i  in  1  downstream accepts result
- y_o  out  DATA_WIDTH  activation result, same Q format as z_i
- sat_o  out  1  sample at y_o was saturated (|z| >= 2^MAX_INT)
- sat_cnt_clr_i  in  1  synchronous clear of the saturation counter
- sat_cnt_o  out  CNT_WIDTH  count of saturated samples accepted

Behaviour:
- Reset (async, rst_ni low): both stage valids = 0; y_o = 0; sat_o = 0; sat_cnt_o = 0; out_valid_o = 0. Reset mid-operation discards in-flight samples.
- Two register stages; latency 2 cycles from accepted input to out_valid_o when there is no stall.
- Global stall enable: en = !out_valid_o | out_ready_i; in_ready_o = en. When en = 0, all stages hold, including y_o and sat_o.
- A sample transfers when in_valid_i & in_ready_o; output handshake completes when out_valid_o & out_ready_i.
- Stage 1 (registered): mode, sign, abs |z|, sat flag, LUT value s_abs = sigmoid(|z|) in Q.FRAC_BITS, rounded to nearest.
  - |z| is taken from the low FRAC_BITS+MAX_INT bits after two's-complement negation.
  - sat = |z| >= 2^(FRAC_BITS+MAX_INT), decided from the upper bits. The most negative input (0x8000) is sat with negative sign.
- Stage 2 (registered):
  - Sigmoid: positive, non-sat -> s_abs; negative, non-sat -> 2^FRAC_BITS - s_abs; positive sat -> 2^FRAC_BITS; negative sat -> 0.
  - Derivative: s_abs * (2^FRAC_BITS - s_abs) >> FRAC_BITS (truncate; result is symmetric in sign); sat -> 0. The product is 2*(FRAC_BITS+1) bits wide, with no overflow.
  - ReLU: z < 0 -> 0, else z.
  - Passthrough: z unchanged.
  - sat_o is the registered sat flag for sigmoid and derivative modes, and 0 for ReLU and passthrough.
  - Results are zero-extended or sign-extended to DATA_WIDTH as appropriate.
- Saturation counter:
  - Increments by 1 when a sample with sat_o = 1 completes its output handshake.
  - Saturates at all-ones; no wrap.
  - sat_cnt_clr_i takes priority over a simultaneous increment, and the counter reads 0 the next cycle.
- Mode is captured with each sample. A mode change between back-to-back samples is legal and needs no bubble.

Decomposition:
- Shared package act_pkg:
  - mode enum act_mode_e (ACT_SIGMOID, ACT_SIGMOID_DERIV, ACT_RELU, ACT_PASS)
  - ONE_FX constant (1 << FRAC_BITS)
  - helper for LUT depth 2^(FRAC_BITS+MAX_INT)
- One sub-module, sigmoid_lut: combinational, address width FRAC_BITS+MAX_INT, output FRAC_BITS+1 bits, content = round(sigmoid(addr/2^FRAC_BITS) * 2^FRAC_BITS).
  - The derivative is derived arithmetically, not from a second LUT.

Test Plan:
- z=0x0000: sigmoid -> y=0x0080, then derivative -> y=0x0040. out_valid_o rises exactly 2 cycles after acceptance; sat_o = 0.
- z=0x0100 (1.0) sigmoid -> 0x00BB; z=0xFF00 (-1.0) sigmoid -> 0x0045; both derivative -> 0x0032.
- Saturation cases, each with sat_o = 1; sat_cnt_o = 4 after the four samples; then sat_cnt_clr_i -> 0:
  - z=0x0800 (8.0): sigmoid -> 0x0100, derivative -> 0x0000
  - z=0xF800: sigmoid -> 0x0000
  - z=0x8000: sigmoid -> 0x0000
- ReLU on z=0xFE00 -> 0x0000 and z=0x0234 -> 0x0234; passthrough on 0xFE00 -> 0xFE00.
- Backpressure and stall:
  - Stream 6 samples with out_ready_i held low 3 cycles mid-stream: no sample is lost or duplicated, order is preserved, y_o is stable while stalled, and in_ready_o = 0 during the stall.
- Reset and counter edge:
  - Assert rst_ni low with 2 samples in flight: outputs are 0 immediately; after release no stale out_valid_o appears.
  - Preset the counter to all-ones via repeated saturated samples with CNT_WIDTH=4: the counter holds at 0xF.

Source files
------------

// File: rtl/act_pkg.sv
// Shared types and constants for the activation unit.
package act_pkg;

    // Per-sample activation select, carried down the pipe with each sample.
    typedef enum logic [1:0] {
        ACT_SIGMOID       = 2'b00,
        ACT_SIGMOID_DERIV = 2'b01,
        ACT_RELU          = 2'b10,
        ACT_PASS          = 2'b11
    } act_mode_e;

    localparam int ACT_FRAC_BITS = 8;
    localparam int ONE_FX        = 1 << ACT_FRAC_BITS;

    // Fixed-point 1.0 for a given number of fractional bits.
    function automatic int one_fx(input int frac_bits);
        return 1 << frac_bits;
    endfunction

    // Number of LUT entries: one per representable |z| below 2^max_int.
    function automatic int lut_depth(input int frac_bits, input int max_int);
        return 1 << (frac_bits + max_int);
    endfunction

endpackage

// File: rtl/sigmoid_lut.sv
// Combinational sigmoid table: s = round(sigmoid(addr / 2^FRAC_BITS) * 2^FRAC_BITS).
// Contents are computed at elaboration time; the table holds only
// non-negative arguments, the negative half is derived by symmetry.
module sigmoid_lut
    import act_pkg::*;
#(
    parameter int FRAC_BITS = ACT_FRAC_BITS,
    parameter int MAX_INT   = 3,
    parameter int AW        = FRAC_BITS + MAX_INT
) (
    input  logic [AW-1:0]      addr_i,
    output logic [FRAC_BITS:0] s_o
);

    localparam int DEPTH = lut_depth(FRAC_BITS, MAX_INT);

    // exp(-x) by Taylor series on x/16 followed by four squarings, which keeps
    // the series argument small enough for double precision to round exactly.
    function automatic logic [FRAC_BITS:0] lut_entry(input int a);
        real x;
        real t;
        real e;
        int  v;
        x = real'(a) / real'(2 ** FRAC_BITS) / 16.0;
        t = 1.0;
        e = 1.0;
        for (int k = 1; k < 20; k++) begin
            t = -t * x / real'(k);
            e = e + t;
        end
        for (int k = 0; k < 4; k++) begin
            e = e * e;
        end
        v = $rtoi(real'(2 ** FRAC_BITS) / (1.0 + e) + 0.5);
        return (FRAC_BITS + 1)'(v);
    endfunction

    logic [FRAC_BITS:0] rom [DEPTH];

    // Constant table, one entry per address.
    for (genvar a = 0; a < DEPTH; a++) begin : g_rom
        assign rom[a] = lut_entry(a);
    end

    assign s_o = rom[addr_i];

endmodule

// File: rtl/act_unit_pipe.sv
// Two-stage pipelined activation unit: sigmoid, sigmoid derivative, ReLU or
// passthrough per sample, plus a saturating count of saturated results.
//
// Handshake: a sample moves in when in_valid_i & in_ready_o, and a result
// moves out when out_valid_o & out_ready_i. The whole pipe advances on
// en = !out_valid_o | out_ready_i (in_ready_o = en); when en is low every
// stage, including y_o and sat_o, holds its value.
module act_unit_pipe
    import act_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = ACT_FRAC_BITS,
    parameter int MAX_INT    = 3,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] z_i,
    input  logic [1:0]            mode_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] y_o,
    output logic                  sat_o,
    input  logic                  sat_cnt_clr_i,
    output logic [CNT_WIDTH-1:0]  sat_cnt_o
);

    localparam int AW = FRAC_BITS + MAX_INT;
    localparam int SW = FRAC_BITS + 1;
    localparam logic [SW-1:0] ONE = SW'(one_fx(FRAC_BITS));

    logic en;
    assign en         = !out_valid_o || out_ready_i;
    assign in_ready_o = en;

    // Stage 1 inputs: magnitude via two's-complement negation; anything with
    // bits set above the LUT range (including the most negative code) saturates.
    logic                  sign_c;
    logic [DATA_WIDTH-1:0] mag_c;
    logic                  sat_c;
    logic [SW-1:0]         s_c;

    assign sign_c = z_i[DATA_WIDTH-1];
    assign mag_c  = sign_c ? -z_i : z_i;
    assign sat_c  = |mag_c[DATA_WIDTH-1:AW];

    sigmoid_lut #(
        .FRAC_BITS (FRAC_BITS),
        .MAX_INT   (MAX_INT),
        .AW        (AW)
    ) u_lut (
        .addr_i (mag_c[AW-1:0]),
        .s_o    (s_c)
    );

    logic                  v1;
    act_mode_e             mode1;
    logic                  sign1;
    logic                  sat1;
    logic [SW-1:0]         s1;
    logic [DATA_WIDTH-1:0] z1;

    // Stage 1 register: capture mode, sign, saturation and sigmoid(|z|).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v1    <= 1'b0;
            mode1 <= ACT_SIGMOID;
            sign1 <= 1'b0;
            sat1  <= 1'b0;
            s1    <= '0;
            z1    <= '0;
        end else if (en) begin
            v1 <= in_valid_i;
            if (in_valid_i) begin
                mode1 <= act_mode_e'(mode_i);
                sign1 <= sign_c;
                sat1  <= sat_c;
                s1    <= s_c;
                z1    <= z_i;
            end
        end
    end

    // Derivative s*(1-s) is symmetric in sign, so the table value is used as is.
    logic [SW-1:0]   comp_c;
    logic [2*SW-1:0] prod_c;
    logic [2*SW-1:0] deriv_c;
    logic [SW-1:0]   sig_c;

    assign comp_c  = ONE - s1;
    assign prod_c  = {{SW{1'b0}}, s1} * {{SW{1'b0}}, comp_c};
    assign deriv_c = prod_c >> FRAC_BITS;

    // Sigmoid of a negative argument mirrors the table: 1 - sigmoid(|z|).
    always_comb begin
        sig_c = s1;
        if (sat1) begin
            sig_c = sign1 ? '0 : ONE;
        end else if (sign1) begin
            sig_c = ONE - s1;
        end
    end

    logic [DATA_WIDTH-1:0] y_c;
    logic                  sat_n;

    // Stage 2 result select; saturation is only reported for the sigmoid modes.
    always_comb begin
        y_c   = '0;
        sat_n = 1'b0;
        case (mode1)
            ACT_SIGMOID: begin
                y_c   = DATA_WIDTH'(sig_c);
                sat_n = sat1;
            end
            ACT_SIGMOID_DERIV: begin
                y_c   = sat1 ? '0 : DATA_WIDTH'(deriv_c);
                sat_n = sat1;
            end
            ACT_RELU: y_c = sign1 ? '0 : z1;
            ACT_PASS: y_c = z1;
            default:  y_c = '0;
        endcase
    end

    // Stage 2 register: output valid and result.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_o <= 1'b0;
            y_o         <= '0;
            sat_o       <= 1'b0;
        end else if (en) begin
            out_valid_o <= v1;
            if (v1) begin
                y_o   <= y_c;
                sat_o <= sat_n;
            end
        end
    end

    // Saturation event counter: counts saturated results as they leave, sticks at all-ones.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sat_cnt_o <= '0;
        end else if (sat_cnt_clr_i) begin
            sat_cnt_o <= '0;
        end else if (out_valid_o && out_ready_i && sat_o && (sat_cnt_o != '1)) begin
            sat_cnt_o <= sat_cnt_o + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_act_unit_pipe.sv
// Bench for act_unit_pipe: directed cases with known values, a stall,
// a reset with samples in flight, a saturating 4-bit counter, and a
// randomized stream compared against a real-arithmetic sigmoid model.
module tb_act_unit_pipe;

    localparam int W    = 16;
    localparam int F    = 8;
    localparam int ONEI = 256;
    localparam int SATI = 2048;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic         in_valid;
    logic [W-1:0] z;
    logic [1:0]   mode;
    logic         out_ready;
    logic         clr;
    logic         clr4 = 1'b0;

    logic         in_ready_o, out_valid_o, sat_o;
    logic [W-1:0] y_o;
    logic [15:0]  sat_cnt_o;

    logic         in_ready4, out_valid4, sat4;
    logic [W-1:0] y4;
    logic [3:0]   sat_cnt4;

    act_unit_pipe u_dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready_o),
        .z_i           (z),
        .mode_i        (mode),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready),
        .y_o           (y_o),
        .sat_o         (sat_o),
        .sat_cnt_clr_i (clr),
        .sat_cnt_o     (sat_cnt_o)
    );

    act_unit_pipe #(.CNT_WIDTH(4)) u_dut4 (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready4),
        .z_i           (z),
        .mode_i        (mode),
        .out_valid_o   (out_valid4),
        .out_ready_i   (out_ready),
        .y_o           (y4),
        .sat_o         (sat4),
        .sat_cnt_clr_i (clr4),
        .sat_cnt_o     (sat_cnt4)
    );

    // ---------------- bookkeeping ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    logic rand_on = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: {sat, y} from the activation definitions in real arithmetic.
    function automatic logic [W:0] model(input logic [W-1:0] zv, input logic [1:0] mv);
        int   zi, az, sa, y;
        logic neg, sat;
        zi  = int'($signed(zv));
        neg = (zi < 0);
        az  = neg ? -zi : zi;
        sat = (az >= SATI);
        sa  = $rtoi(real'(ONEI) / (1.0 + $exp(-real'(az) / real'(ONEI))) + 0.5);
        case (mv)
            2'd0:    y = sat ? (neg ? 0 : ONEI) : (neg ? ONEI - sa : sa);
            2'd1:    y = sat ? 0 : (sa * (ONEI - sa)) / ONEI;
            2'd2:    y = neg ? 0 : zi;
            default: y = zi;
        endcase
        return {(mv <= 2'd1) ? sat : 1'b0, W'(y)};
    endfunction

    // ---------------- scoreboard ----------------
    logic [W:0] exp_q[$];
    logic [W:0] exp4_q[$];
    int   cnt16 = 0;
    int   cnt4  = 0;
    logic prev_hold = 1'b0;
    logic [W:0] e;
    logic hs_sat, hs4_sat;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            exp4_q.delete();
            cnt16     = 0;
            cnt4      = 0;
            prev_hold = 1'b0;
        end else begin
            check("cnt16", 32'(sat_cnt_o), cnt16);
            check("cnt4", 32'(sat_cnt4), cnt4);
            check("in_ready", in_ready_o, !out_valid_o || out_ready);
            check("in_ready4", in_ready4, !out_valid4 || out_ready);
            if (prev_hold) check("stall_valid", out_valid_o, 1);
            hs_sat  = 1'b0;
            hs4_sat = 1'b0;
            if (out_valid_o) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", out_valid_o, 0);
                end else begin
                    e = exp_q[0];
                    check("y", y_o, e[W-1:0]);
                    check("sat", sat_o, e[W]);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        hs_sat = e[W];
                    end
                end
            end
            if (out_valid4) begin
                if (exp4_q.size() == 0) begin
                    check("spurious_valid4", out_valid4, 0);
                end else begin
                    e = exp4_q[0];
                    check("y4", y4, e[W-1:0]);
                    check("sat4", sat4, e[W]);
                    if (out_ready) begin
                        void'(exp4_q.pop_front());
                        hs4_sat = e[W];
                    end
                end
            end
            prev_hold = out_valid_o && !out_ready;
            if (in_valid && in_ready_o) exp_q.push_back(model(z, mode));
            if (in_valid && in_ready4) exp4_q.push_back(model(z, mode));
            if (clr) cnt16 = 0;
            else if (hs_sat && cnt16 < 65535) cnt16 = cnt16 + 1;
            if (hs4_sat && cnt4 < 15) cnt4 = cnt4 + 1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
        if (rand_on) begin
            out_ready = ($urandom_range(0, 3) != 0);
            clr       = ($urandom_range(0, 7) == 0);
        end
    endtask

    task automatic send(input logic [W-1:0] zv, input logic [1:0] mv);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        z        = zv;
        mode     = mv;
        @(negedge clk);
        while (!in_ready_o && waited < 100) begin
            step();
            @(negedge clk);
            waited++;
        end
        check("send_timeout", waited < 100, 1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [W-1:0] yv, input logic sv);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid_o) break;
        end
        check({tag, "_valid"}, out_valid_o, 1);
        check(tag, y_o, yv);
        check({tag, "_sat"}, sat_o, sv);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        rand_on   = 1'b0;
        out_ready = 1'b1;
        clr       = 1'b0;
        for (int i = 0; i < 50 && (exp_q.size() != 0 || exp4_q.size() != 0); i++) @(negedge clk);
        check("drain", exp_q.size(), 0);
        check("drain4", exp4_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rand_z();
        int r, zi;
        r = $urandom_range(0, 3);
        if (r == 0)      zi = int'($urandom_range(0, 65535));
        else if (r == 1) zi = ($urandom_range(0, 1) ? SATI : -SATI) + int'($urandom_range(0, 3)) - 2;
        else             zi = int'($urandom_range(0, 2 * SATI - 1)) - SATI;
        return W'(zi);
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        z         = '0;
        mode      = 2'd0;
        out_ready = 1'b1;
        clr       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", out_valid_o, 0);
        check("rst_y", y_o, 0);
        check("rst_sat", sat_o, 0);
        check("rst_cnt", 32'(sat_cnt_o), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // latency of a single sigmoid(0)
        in_valid = 1'b1;
        z        = 16'h0000;
        mode     = 2'd0;
        @(negedge clk);
        check("lat_accept", in_ready_o, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("lat_cycle1", out_valid_o, 0);
        @(negedge clk);
        check("lat_cycle2", out_valid_o, 1);
        check("lat_y", y_o, 16'h0080);
        check("lat_sat", sat_o, 0);
        @(posedge clk);
        #1;

        send(16'h0000, 2'd1); expect_out("deriv_0", 16'h0040, 1'b0);
        send(16'h0100, 2'd0); expect_out("sig_p1", 16'h00BB, 1'b0);
        send(16'hFF00, 2'd0); expect_out("sig_m1", 16'h0045, 1'b0);
        send(16'h0100, 2'd1); expect_out("deriv_p1", 16'h0032, 1'b0);
        send(16'hFF00, 2'd1); expect_out("deriv_m1", 16'h0032, 1'b0);

        // saturation and counter clear
        send(16'h0800, 2'd0); expect_out("sat_p8", 16'h0100, 1'b1);
        send(16'h0800, 2'd1); expect_out("sat_d8", 16'h0000, 1'b1);
        send(16'hF800, 2'd0); expect_out("sat_m8", 16'h0000, 1'b1);
        send(16'h8000, 2'd0); expect_out("sat_min", 16'h0000, 1'b1);
        check("sat_cnt_4", 32'(sat_cnt_o), 4);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        check("sat_cnt_clr", 32'(sat_cnt_o), 0);

        // ReLU / passthrough
        send(16'hFE00, 2'd2); expect_out("relu_neg", 16'h0000, 1'b0);
        send(16'h0234, 2'd2); expect_out("relu_pos", 16'h0234, 1'b0);
        send(16'hFE00, 2'd3); expect_out("pass_neg", 16'hFE00, 1'b0);

        // six-sample stream with a three-cycle output stall
        for (int i = 0; i < 3; i++) send(rand_z(), 2'($urandom_range(0, 3)));
        out_ready = 1'b0;
        in_valid  = 1'b1;
        z         = rand_z();
        mode      = 2'($urandom_range(0, 3));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", in_ready_o, 0);
            check("stall_out_valid", out_valid_o, 1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("unstall_in_ready", in_ready_o, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) send(rand_z(), 2'($urandom_range(0, 3)));
        drain();

        // randomized stream with random backpressure and clears
        rand_on = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 4) == 0) step();
            send(rand_z(), 2'($urandom_range(0, 3)));
        end
        drain();

        // reset with two samples in flight
        send(16'h0800, 2'd0);
        send(16'h0300, 2'd0);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", out_valid_o, 0);
        check("midrst_y", y_o, 0);
        check("midrst_sat", sat_o, 0);
        check("midrst_cnt", 32'(sat_cnt_o), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("no_stale", out_valid_o, 0);
            @(posedge clk);
            #1;
        end

        // 20 saturated samples: the 4-bit counter must stick at 0xF
        for (int i = 0; i < 20; i++) begin
            int zi;
            zi = int'($urandom_range(SATI, 32767));
            if ($urandom_range(0, 1) == 1) zi = -zi - int'($urandom_range(0, 1));
            send(W'(zi), 2'($urandom_range(0, 1)));
        end
        drain();
        check("cnt4_hold", 32'(sat_cnt4), 32'hF);
        check("cnt16_20", 32'(sat_cnt_o), 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Time limit for the whole run.
    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
